strobe_gen: RTL and testbench

Programmable periodic strobe generator: after a start request it drives a registered pulse train with run-time period, pulse width and burst length, either continuously or for a fixed number of pulses. It supersedes the fixed 1-in-4 start-aligned pulser. It sits beside sequencing logic that needs phase-aligned enables (ADC sampling, LED/PWM strobes, frame ticks).

---
 rtl/strobe_pkg.sv | 16 +
 rtl/strobe_gen.sv | 140 ++++++++++++++
 tb/tb_strobe_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/strobe_pkg.sv
// Shared types and constants for the programmable strobe generator.
// Imported by strobe_gen and by anything that drives its mode input.
package strobe_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int BURST_W_DEF = 8;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/strobe_gen.sv
// Programmable periodic strobe generator.
// Run-time period, pulse width and burst length; continuous or burst mode.
module strobe_gen
  import strobe_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   pulse_len,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               mode_q, mode_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   eff_len;
  logic [CNT_W-1:0]   phase_nxt;
  logic               cfg_bad;
  logic               wrap;

  // Clamp the requested width so every period has at least one low cycle
  always_comb begin
    eff_len = pulse_len;
    if (pulse_len == '0) begin
      eff_len = CNT_W'(1);
    end else if (pulse_len >= period) begin
      eff_len = period - CNT_W'(1);
    end
  end

  // Start validity and phase wrap detection
  always_comb begin
    cfg_bad = (period < CNT_W'(2)) ||
              ((mode == MODE_BURST) && (burst_cnt == '0));
    wrap      = (phase_q == per_q - CNT_W'(1));
    phase_nxt = wrap ? '0 : phase_q + CNT_W'(1);
  end

  // Next-state: run step, then start/stop overrides (stop has priority)
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    per_d   = per_q;
    len_d   = len_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q == RUN) begin
      phase_d = phase_nxt;
      out_d   = (phase_nxt < len_q);
      if (wrap && (mode_q == MODE_BURST)) begin
        rem_d = rem_q - BURST_W'(1);
        if (rem_q == BURST_W'(1)) begin
          state_d = IDLE;
          phase_d = '0;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end

    if (stop) begin
      state_d = IDLE;
      phase_d = '0;
      out_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start && !cfg_bad) begin
      state_d = RUN;
      phase_d = '0;
      per_d   = period;
      len_d   = eff_len;
      rem_d   = burst_cnt;
      mode_d  = mode;
      out_d   = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (start) begin
      // A rejected start never overlaps a completion flag
      err_d = ~done_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      per_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_CONT;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Self-checking bench for strobe_gen.
// Cycle model from pulse-train arithmetic plus directed literal checks.
module tb_strobe_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] pulse_len = 8'd0;
  logic [7:0] burst_cnt = 8'd0;
  logic       out, busy, done, cfg_err;

  int n_checks = 0;
  int n_fail = 0;

  strobe_gen #(.CNT_W(8), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mode(mode), .period(period), .pulse_len(pulse_len),
    .burst_cnt(burst_cnt), .out(out), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: train position counted in cycles since the start
  bit m_run = 0;
  bit m_mode = 0;
  int m_n = 0, m_per = 0, m_len = 0, m_b = 0;
  bit e_out = 0, e_busy = 0, e_done = 0, e_err = 0;

  task automatic m_adv();
    m_n++;
    if (m_mode && m_n == m_b * m_per) begin
      m_run = 0;
      e_done = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; e_out = 0; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      e_done = 0;
      e_err = 0;
      if (stop) begin
        m_run = 0;
      end else if (start && (period < 2 || (mode && burst_cnt == 0))) begin
        if (m_run) m_adv();
        e_err = !e_done;
      end else if (start) begin
        m_run = 1;
        m_n = 0;
        m_per = period;
        m_mode = mode;
        m_b = burst_cnt;
        if (pulse_len == 0) m_len = 1;
        else if (pulse_len >= period) m_len = period - 1;
        else m_len = pulse_len;
      end else if (m_run) begin
        m_adv();
      end
      e_busy = m_run;
      e_out = m_run && ((m_n % m_per) < m_len);
    end
  end

  // Compare DUT against model every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_out", out, e_out);
      chk("m_busy", busy, e_busy);
      chk("m_done", done, e_done);
      chk("m_cfg_err", cfg_err, e_err);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  logic [7:0]  pat8;
  logic [14:0] pat15;
  logic [5:0]  pat6;
  int busy_cyc;

  initial begin
    #1;
    chk("rst_out", out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    step(2);
    rst = 1'b0;
    step(1);

    // continuous 1-in-4
    period = 8'd4; pulse_len = 8'd1; mode = 1'b0;
    do_start();
    pat8 = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      chk("cont4_out", out, pat8[7-i]);
      chk("cont4_busy", busy, 1'b1);
      step(1);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_out", out, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_done", done, 1'b0);
    step(2);

    // burst of three, period 5, width 2
    period = 8'd5; pulse_len = 8'd2; mode = 1'b1; burst_cnt = 8'd3;
    do_start();
    pat15 = 15'b11000_11000_11000;
    busy_cyc = 0;
    for (int i = 0; i < 15; i++) begin
      chk("burst_out", out, pat15[14-i]);
      chk("burst_done_early", done, 1'b0);
      if (busy) busy_cyc++;
      step(1);
    end
    chk_int("burst_busy_cycles", busy_cyc, 15);
    chk("burst_end_busy", busy, 1'b0);
    chk("burst_end_done", done, 1'b1);
    step(1);
    chk("burst_done_1cyc", done, 1'b0);
    step(2);

    // width clamping at period 6
    period = 8'd6; pulse_len = 8'd0; mode = 1'b0;
    do_start();
    pat6 = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      chk("len0_out", out, pat6[5-i]);
      step(1);
    end
    pulse_len = 8'd9;
    do_start();
    pat6 = 6'b111110;
    for (int i = 0; i < 6; i++) begin
      chk("len9_out", out, pat6[5-i]);
      step(1);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);

    // rejections while idle
    period = 8'd1; pulse_len = 8'd1;
    do_start();
    chk("rej_p1_err", cfg_err, 1'b1);
    chk("rej_p1_busy", busy, 1'b0);
    step(1);
    chk("rej_p1_err_clr", cfg_err, 1'b0);
    period = 8'd4; mode = 1'b1; burst_cnt = 8'd0;
    do_start();
    chk("rej_b0_err", cfg_err, 1'b1);
    chk("rej_b0_busy", busy, 1'b0);
    step(1);

    // rejection mid-train keeps the train running
    period = 8'd4; pulse_len = 8'd2; mode = 1'b0; burst_cnt = 8'd1;
    do_start();
    chk("mt_ph0_out", out, 1'b1);
    period = 8'd1;
    do_start();
    chk("mt_rej_err", cfg_err, 1'b1);
    chk("mt_rej_out", out, 1'b1);
    chk("mt_rej_busy", busy, 1'b1);
    step(1);
    chk("mt_ph2_out", out, 1'b0);
    chk("mt_ph2_err", cfg_err, 1'b0);

    // restart at phase 2 with period 3
    period = 8'd3; pulse_len = 8'd1;
    do_start();
    chk("rs_done", done, 1'b0);
    pat6 = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      chk("rs_out", out, pat6[5-i]);
      chk("rs_busy", busy, 1'b1);
      step(1);
    end

    // start and stop together
    period = 8'd4; start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 1'b0);
    chk("ss_out", out, 1'b0);
    chk("ss_err", cfg_err, 1'b0);
    step(2);

    // asynchronous reset mid-burst
    period = 8'd5; pulse_len = 8'd2; mode = 1'b1; burst_cnt = 8'd3;
    do_start();
    step(1);
    chk("pre_rst_out", out, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_out", out, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("post_rst_out", out, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
